// File: rtl/hpdmc_wrfeed_pkg.sv
// Shared HPDMC definitions: write-feed FSM encoding, parameter limits and
// the DDR data-mask polarity.
package hpdmc_wrfeed_pkg;

    typedef enum logic [1:0] {
        WF_IDLE = 2'd0,
        WF_LAT  = 2'd1,
        WF_DATA = 2'd2
    } wf_state_t;

    localparam int WLAT_MIN  = 1;
    localparam int WLAT_MAX  = 15;
    localparam int BURST_MIN = 1;
    localparam int BURST_MAX = 8;
    localparam int CNT_W     = 4;

    // DDR DM pins are active-high masks: a 1 blocks the byte write.
    localparam logic       DM_MASKED = 1'b1;
    localparam logic [1:0] DM_IDLE   = {2{DM_MASKED}};

endpackage

// File: rtl/hpdmc_wrfeed.sv
// Write-data feeder for the HPDMC DDR controller: waits the write latency after
// a WRITE command, then streams BURST_WORDS words as two 16-bit DDR beats each.
module hpdmc_wrfeed
    import hpdmc_wrfeed_pkg::*;
#(
    parameter int WLAT        = 2,
    parameter int BURST_WORDS = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        wr_start,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_mask,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [15:0] dq_d0,
    output logic [15:0] dq_d1,
    output logic [1:0]  dm_d0,
    output logic [1:0]  dm_d1,
    output logic        dq_oe,
    output logic        dqs_oe,
    output logic        wr_done,
    output logic        wr_underrun,
    output logic        wr_overlap
);

    if (WLAT < WLAT_MIN || WLAT > WLAT_MAX) begin : g_bad_wlat
        $error("hpdmc_wrfeed: WLAT out of range");
    end
    if (BURST_WORDS < BURST_MIN || BURST_WORDS > BURST_MAX) begin : g_bad_burst
        $error("hpdmc_wrfeed: BURST_WORDS out of range");
    end

    localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(WLAT - 1);
    localparam logic [CNT_W-1:0] BEAT_LOAD  = CNT_W'(BURST_WORDS - 1);

    wf_state_t        state_q, state_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [15:0]      dq0_q, dq0_d, dq1_q, dq1_d;
    logic [1:0]       dm0_q, dm0_d, dm1_q, dm1_d;
    logic             dq_oe_q, dq_oe_d;
    logic             dqs_oe_q, dqs_oe_d;
    logic             done_q, done_d;
    logic             under_q, under_d;
    logic             over_q, over_d;
    logic             launch, capture, last_cap, take;

    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        beat_d   = beat_q;
        over_d   = over_q;
        launch   = 1'b0;
        capture  = 1'b0;
        last_cap = 1'b0;

        case (state_q)
            WF_IDLE: launch = wr_start;
            WF_LAT: begin
                over_d = over_q | wr_start;
                lat_d  = lat_q - CNT_W'(1);
                if (lat_d == '0) begin
                    state_d = WF_DATA;
                    beat_d  = BEAT_LOAD;
                end
            end
            WF_DATA: begin
                capture = 1'b1;
                if (beat_q == '0) begin
                    last_cap = 1'b1;
                    state_d  = WF_IDLE;
                    launch   = wr_start;
                end else begin
                    beat_d = beat_q - CNT_W'(1);
                    over_d = over_q | wr_start;
                end
            end
            default: state_d = WF_IDLE;
        endcase

        // The latency count is consumed on the decrement, so WLAT=1 skips LAT entirely.
        if (launch) begin
            if (LAT_LOAD == '0) begin
                state_d = WF_DATA;
                lat_d   = '0;
                beat_d  = BEAT_LOAD;
            end else begin
                state_d = WF_LAT;
                lat_d   = LAT_LOAD;
            end
        end

        take     = capture & wr_valid;
        dq0_d    = take ? wr_data[31:16] : 16'h0000;
        dq1_d    = take ? wr_data[15:0]  : 16'h0000;
        dm0_d    = take ? ~wr_mask[3:2]  : DM_IDLE;
        dm1_d    = take ? ~wr_mask[1:0]  : DM_IDLE;
        dq_oe_d  = capture;
        dqs_oe_d = capture | (state_d == WF_DATA);
        done_d   = last_cap;
        under_d  = under_q | (capture & ~wr_valid);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= WF_IDLE;
            lat_q    <= '0;
            beat_q   <= '0;
            dq0_q    <= 16'h0000;
            dq1_q    <= 16'h0000;
            dm0_q    <= DM_IDLE;
            dm1_q    <= DM_IDLE;
            dq_oe_q  <= 1'b0;
            dqs_oe_q <= 1'b0;
            done_q   <= 1'b0;
            under_q  <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            beat_q   <= beat_d;
            dq0_q    <= dq0_d;
            dq1_q    <= dq1_d;
            dm0_q    <= dm0_d;
            dm1_q    <= dm1_d;
            dq_oe_q  <= dq_oe_d;
            dqs_oe_q <= dqs_oe_d;
            done_q   <= done_d;
            under_q  <= under_d;
            over_q   <= over_d;
        end
    end

    assign wr_ready    = (state_q == WF_DATA);
    assign dq_d0       = dq0_q;
    assign dq_d1       = dq1_q;
    assign dm_d0       = dm0_q;
    assign dm_d1       = dm1_q;
    assign dq_oe       = dq_oe_q;
    assign dqs_oe      = dqs_oe_q;
    assign wr_done     = done_q;
    assign wr_underrun = under_q;
    assign wr_overlap  = over_q;

endmodule

// File: tb/tb_hpdmc_wrfeed.sv
// Self-checking bench for hpdmc_wrfeed: cycle-indexed burst schedule model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_hpdmc_wrfeed;

    localparam int WLAT  = 2;
    localparam int BURST = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] data = '0;
    logic [3:0]  mask = '0;
    logic        valid = 1'b0;
    logic        wr_ready, dq_oe, dqs_oe, wr_done, wr_underrun, wr_overlap;
    logic [15:0] dq_d0, dq_d1;
    logic [1:0]  dm_d0, dm_d1;

    int n_chk = 0;
    int n_fail = 0;

    hpdmc_wrfeed #(.WLAT(WLAT), .BURST_WORDS(BURST)) dut (
        .sys_clk(clk), .sys_rst(rst), .wr_start(start), .wr_data(data),
        .wr_mask(mask), .wr_valid(valid), .wr_ready(wr_ready),
        .dq_d0(dq_d0), .dq_d1(dq_d1), .dm_d0(dm_d0), .dm_d1(dm_d1),
        .dq_oe(dq_oe), .dqs_oe(dqs_oe), .wr_done(wr_done),
        .wr_underrun(wr_underrun), .wr_overlap(wr_overlap)
    );

    always #5 clk = ~clk;

    // Model: the accepted burst is remembered as the absolute cycle range of its
    // capture slots; registered outputs are what the previous cycle produced.
    int          cyc = 0;
    bit          m_known = 0;
    bit          m_have = 0;
    int          m_first = 0, m_last = 0;
    logic [15:0] e_dq0 = 0, e_dq1 = 0;
    logic [1:0]  e_dm0 = 2'b11, e_dm1 = 2'b11;
    logic        e_dqoe = 0, e_done = 0, e_under = 0, e_over = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit slot(input int c);
        return m_have && c >= m_first && c <= m_last;
    endfunction

    task automatic step(input logic r, input logic s, input logic v,
                        input logic [31:0] d, input logic [3:0] m);
        bit cap, fin, busy;
        @(posedge clk);
        #1;
        rst = r; start = s; valid = v; data = d; mask = m;
        @(negedge clk);
        cap = slot(cyc);
        if (m_known) begin
            chk("wr_ready", wr_ready, cap);
            chk("dq_d0", dq_d0, e_dq0);
            chk("dq_d1", dq_d1, e_dq1);
            chk("dm_d0", dm_d0, e_dm0);
            chk("dm_d1", dm_d1, e_dm1);
            chk("dq_oe", dq_oe, e_dqoe);
            chk("dqs_oe", dqs_oe, cap | e_dqoe);
            chk("wr_done", wr_done, e_done);
            chk("wr_underrun", wr_underrun, e_under);
            chk("wr_overlap", wr_overlap, e_over);
        end
        if (r) begin
            m_known = 1; m_have = 0;
            e_dq0 = 0; e_dq1 = 0; e_dm0 = 2'b11; e_dm1 = 2'b11;
            e_dqoe = 0; e_done = 0; e_under = 0; e_over = 0;
        end else begin
            fin    = cap && (cyc == m_last);
            busy   = m_have && (cyc <= m_last);
            e_dqoe = cap;
            e_done = fin;
            e_dq0  = (cap && v) ? d[31:16] : 16'h0;
            e_dq1  = (cap && v) ? d[15:0]  : 16'h0;
            e_dm0  = (cap && v) ? ~m[3:2]  : 2'b11;
            e_dm1  = (cap && v) ? ~m[1:0]  : 2'b11;
            if (cap && !v) e_under = 1;
            if (s) begin
                if (!busy || fin) begin
                    m_have = 1; m_first = cyc + WLAT; m_last = cyc + WLAT + BURST - 1;
                end else begin
                    e_over = 1;
                end
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        step(1, 0, 0, 32'h0, 4'h0);
        step(1, 1, 1, 32'hDEADBEEF, 4'hF);
        step(0, 0, 0, 32'h0, 4'h0);
        chk("rst_underrun", wr_underrun, 0);
        chk("rst_dm_d0", dm_d0, 2'b11);
    endtask

    logic [31:0] words [4];

    initial begin
        words[0] = 32'h11112222; words[1] = 32'h33334444;
        words[2] = 32'h55556666; words[3] = 32'h77778888;

        // Basic burst with mask on the first word
        do_reset();
        for (int r = 0; r < 10; r++) begin
            step(0, r == 0, 1, (r >= 2 && r <= 5) ? words[r-2] : $urandom,
                 (r == 2) ? 4'b1010 : 4'hF);
            if (r == 1) chk("lit_dqs_pre", dqs_oe, 0);
            if (r == 2) begin chk("lit_ready2", wr_ready, 1); chk("lit_dqs2", dqs_oe, 1); chk("lit_dqoe2", dq_oe, 0); end
            if (r == 3) begin
                chk("lit_dq0_3", dq_d0, 16'h1111); chk("lit_dq1_3", dq_d1, 16'h2222);
                chk("lit_dm0_3", dm_d0, 2'b01);    chk("lit_dm1_3", dm_d1, 2'b01);
            end
            if (r == 6) begin chk("lit_done6", wr_done, 1); chk("lit_dq0_6", dq_d0, 16'h7777); chk("lit_ready6", wr_ready, 0); end
            if (r == 7) begin chk("lit_dqoe7", dq_oe, 0); chk("lit_dqs7", dqs_oe, 0); end
        end

        // Underrun on the third capture slot
        for (int r = 0; r < 9; r++) begin
            step(0, r == 0, r != 4, $urandom, $urandom);
            if (r == 5) begin chk("lit_ur_dq0", dq_d0, 16'h0); chk("lit_ur_dm1", dm_d1, 2'b11); chk("lit_ur_flag", wr_underrun, 1); end
            if (r == 6) chk("lit_ur_done", wr_done, 1);
        end

        // Back-to-back bursts
        do_reset();
        for (int r = 0; r < 14; r++) begin
            step(0, r == 0 || r == 5, 1, $urandom, $urandom);
            if (r == 7) begin chk("lit_b2b_ready7", wr_ready, 1); chk("lit_b2b_dqoe7", dq_oe, 0); end
            if (r == 11) chk("lit_b2b_dqoe11", dq_oe, 1);
            if (r == 12) chk("lit_b2b_over", wr_overlap, 0);
        end

        // Overlapping start is ignored
        for (int r = 0; r < 9; r++) begin
            step(0, r == 0 || r == 3, 1, $urandom, $urandom);
            if (r == 4) chk("lit_ovl_flag", wr_overlap, 1);
            if (r == 6) chk("lit_ovl_done", wr_done, 1);
            if (r == 7) chk("lit_ovl_ready7", wr_ready, 0);
        end

        // Reset mid-burst, then a fresh burst
        for (int r = 0; r < 18; r++) begin
            step(r == 4, r == 0 || r == 7, 1, $urandom, $urandom);
            if (r == 5) begin chk("lit_rm_dqoe", dq_oe, 0); chk("lit_rm_over", wr_overlap, 0); end
            if (r == 6) chk("lit_rm_done", wr_done, 0);
            if (r == 9) chk("lit_rm_ready9", wr_ready, 1);
            if (r == 13) chk("lit_rm_done13", wr_done, 1);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) != 0, $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
